// File: rtl/password_change_entry.sv
// password_change_entry
//   Edits and confirms a new 4-digit unlock password while the gate FSM
//   reports CHANGE_PASSWORD (3'd4). The user edits the digits in a first pass
//   and re-enters them in a second pass. If both passes match, the password is
//   committed and OPEN status is returned. If they differ, the first pass is
//   restarted. Cancel and idle timeout return OPEN without a commit.
//
//   Ports
//     clk, rst         clock, asynchronous active-high reset
//     gate_status      current gate FSM status (4 = CHANGE_PASSWORD)
//     start_index      digit index where editing starts
//     seed_password    initial edit-buffer contents
//     up_btn, next_btn, enter_btn, cancel_btn   raw button levels
//     entry_index      digit currently being edited
//     entry_digit      value of that digit
//     stored_password  committed unlock password
//     commit_pulse     one cycle when a new password is committed
//     mismatch_pulse   one cycle when the confirm pass differs
//     busy             high in FIRST / SECOND
//     return_status    status handed back to the gate FSM
//     status_valid     one cycle qualifying return_status
module password_change_entry #(
  parameter int          DIGIT_MAX      = 9,
  parameter int          TIMEOUT_CYCLES = 500000000,
  parameter logic [15:0] RESET_PASSWORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  gate_status,
  input  logic [1:0]  start_index,
  input  logic [15:0] seed_password,
  input  logic        up_btn,
  input  logic        next_btn,
  input  logic        enter_btn,
  input  logic        cancel_btn,
  output logic [1:0]  entry_index,
  output logic [3:0]  entry_digit,
  output logic [15:0] stored_password,
  output logic        commit_pulse,
  output logic        mismatch_pulse,
  output logic        busy,
  output logic [2:0]  return_status,
  output logic        status_valid
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    D_MAX  = 4'(DIGIT_MAX);
  localparam logic [2:0]    ST_OPEN   = 3'd1;
  localparam logic [2:0]    ST_IDLE   = 3'd2;
  localparam logic [2:0]    ST_CHANGE = 3'd4;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t        state;
  logic [15:0]   editBuf;
  logic [15:0]   firstPw;
  logic [TW-1:0] timer;
  logic          upHist, nextHist, enterHist, cancelHist;
  logic          upEdge, nextEdge, enterEdge, cancelEdge;
  logic          timeout;
  logic          inChange;

  // index 0 is the most significant nibble
  function automatic logic [3:0] nibbleAt(input logic [15:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  // Increment one digit; anything at or above DIGIT_MAX wraps to 0, which
  // also cleans up out-of-range seed digits.
  function automatic logic [15:0] bumpNibble(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0]  n;
    logic [15:0] r;
    n = nibbleAt(v, idx);
    n = (n >= D_MAX) ? 4'd0 : n + 4'd1;
    r = v;
    case (idx)
      2'd0:    r[15:12] = n;
      2'd1:    r[11:8]  = n;
      2'd2:    r[7:4]   = n;
      default: r[3:0]   = n;
    endcase
    return r;
  endfunction

  assign upEdge     = up_btn     & ~upHist;
  assign nextEdge   = next_btn   & ~nextHist;
  assign enterEdge  = enter_btn  & ~enterHist;
  assign cancelEdge = cancel_btn & ~cancelHist;
  assign timeout    = (timer == T_LAST);
  assign inChange   = (gate_status == ST_CHANGE);

  always_comb begin
    entry_digit = nibbleAt(editBuf, entry_index);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      editBuf         <= 16'h0000;
      firstPw         <= 16'h0000;
      entry_index     <= 2'd0;
      timer           <= '0;
      stored_password <= RESET_PASSWORD;
      commit_pulse    <= 1'b0;
      mismatch_pulse  <= 1'b0;
      status_valid    <= 1'b0;
      busy            <= 1'b0;
      return_status   <= ST_IDLE;
      upHist          <= 1'b0;
      nextHist        <= 1'b0;
      enterHist       <= 1'b0;
      cancelHist      <= 1'b0;
    end else begin
      upHist         <= up_btn;
      nextHist       <= next_btn;
      enterHist      <= enter_btn;
      cancelHist     <= cancel_btn;
      commit_pulse   <= 1'b0;
      mismatch_pulse <= 1'b0;
      status_valid   <= 1'b0;

      case (state)
        IDLE: begin
          busy  <= 1'b0;
          timer <= '0;
          if (inChange) begin
            editBuf     <= seed_password;
            entry_index <= start_index;
            state       <= FIRST;
            busy        <= 1'b1;
          end
        end

        FIRST, SECOND: begin
          if (!inChange) begin
            // Gate left early: drop out silently, next entry reloads buffers
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else if (cancelEdge || timeout) begin
            return_status <= ST_OPEN;
            status_valid  <= 1'b1;
            state         <= DONE;
            busy          <= 1'b0;
            timer         <= '0;
          end else if (enterEdge) begin
            timer <= '0;
            if (state == FIRST) begin
              firstPw     <= editBuf;
              editBuf     <= 16'h0000;
              entry_index <= 2'd0;
              state       <= SECOND;
            end else if (editBuf == firstPw) begin
              stored_password <= editBuf;
              commit_pulse    <= 1'b1;
              return_status   <= ST_OPEN;
              status_valid    <= 1'b1;
              state           <= DONE;
              busy            <= 1'b0;
            end else begin
              mismatch_pulse <= 1'b1;
              editBuf        <= seed_password;
              entry_index    <= 2'd0;
              state          <= FIRST;
            end
          end else if (nextEdge) begin
            entry_index <= entry_index + 2'd1;
            timer       <= '0;
          end else if (upEdge) begin
            editBuf <= bumpNibble(editBuf, entry_index);
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          // Wait for the gate FSM to leave CHANGE_PASSWORD before rearming
          busy  <= 1'b0;
          timer <= '0;
          if (!inChange) state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_change_entry.sv
module tb_password_change_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  gate_status;
  logic [1:0]  start_index;
  logic [15:0] seed_password;
  logic        up_btn, next_btn, enter_btn, cancel_btn;
  logic [1:0]  entry_index;
  logic [3:0]  entry_digit;
  logic [15:0] stored_password;
  logic        commit_pulse, mismatch_pulse, busy, status_valid;
  logic [2:0]  return_status;

  int nCmp = 0;
  int nErr = 0;

  password_change_entry #(
    .DIGIT_MAX(9),
    .TIMEOUT_CYCLES(16),
    .RESET_PASSWORD(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gate_status(gate_status),
    .start_index(start_index),
    .seed_password(seed_password),
    .up_btn(up_btn),
    .next_btn(next_btn),
    .enter_btn(enter_btn),
    .cancel_btn(cancel_btn),
    .entry_index(entry_index),
    .entry_digit(entry_digit),
    .stored_password(stored_password),
    .commit_pulse(commit_pulse),
    .mismatch_pulse(mismatch_pulse),
    .busy(busy),
    .return_status(return_status),
    .status_valid(status_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressUp(input int n);
    for (int i = 0; i < n; i++) begin
      up_btn = 1'b1; tick();
      up_btn = 1'b0; tick();
    end
  endtask

  task automatic pressNext(input int n);
    for (int i = 0; i < n; i++) begin
      next_btn = 1'b1; tick();
      next_btn = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gate_status = 3'd2; start_index = 2'd0; seed_password = 16'h1234;
    up_btn = 0; next_btn = 0; enter_btn = 0; cancel_btn = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_busy got %b want 0", busy); end
    nCmp++; if (return_status !== 3'd2) begin nErr++; $display("FAIL reset_status got %0d want 2", return_status); end
    nCmp++; if (stored_password !== 16'h0000) begin nErr++; $display("FAIL reset_stored got %h want 0000", stored_password); end
    nCmp++; if (entry_index !== 2'd0) begin nErr++; $display("FAIL reset_index got %0d want 0", entry_index); end
    nCmp++; if (status_valid !== 1'b0) begin nErr++; $display("FAIL reset_valid got %b want 0", status_valid); end
  endtask

  task automatic test_entry();
    gate_status = 3'd4;
    tick();
    nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL entry_busy got %b want 1", busy); end
    nCmp++; if (entry_digit !== 4'd1) begin nErr++; $display("FAIL entry_digit got %0d want 1", entry_digit); end
    nCmp++; if (stored_password !== 16'h0000) begin nErr++; $display("FAIL entry_stored got %h want 0000", stored_password); end
  endtask

  task automatic test_up_next();
    pressUp(1);
    nCmp++; if (entry_digit !== 4'd2) begin nErr++; $display("FAIL up_single got %0d want 2", entry_digit); end
    pressUp(7);
    nCmp++; if (entry_digit !== 4'd9) begin nErr++; $display("FAIL up_to_max got %0d want 9", entry_digit); end
    pressUp(1);
    nCmp++; if (entry_digit !== 4'd0) begin nErr++; $display("FAIL up_wrap got %0d want 0", entry_digit); end
    pressNext(1);
    nCmp++; if (entry_index !== 2'd1 || entry_digit !== 4'd2) begin nErr++;
      $display("FAIL next_one got idx %0d digit %0d want idx 1 digit 2", entry_index, entry_digit); end
    pressNext(3);
    nCmp++; if (entry_index !== 2'd0) begin nErr++; $display("FAIL next_wrap got %0d want 0", entry_index); end
  endtask

  task automatic test_commit();
    // buffer is 0234 at index 0; edit to 5678
    pressUp(5); pressNext(1); pressUp(4); pressNext(1); pressUp(4); pressNext(1); pressUp(4);
    enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
    nCmp++; if (busy !== 1'b1 || entry_index !== 2'd0 || entry_digit !== 4'd0) begin nErr++;
      $display("FAIL second_start got busy %b idx %0d digit %0d want 1 0 0", busy, entry_index, entry_digit); end
    pressUp(5); pressNext(1); pressUp(6); pressNext(1); pressUp(7); pressNext(1); pressUp(8);
    enter_btn = 1'b1; tick();
    nCmp++; if (commit_pulse !== 1'b1) begin nErr++; $display("FAIL commit_pulse got %b want 1", commit_pulse); end
    nCmp++; if (stored_password !== 16'h5678) begin nErr++; $display("FAIL commit_stored got %h want 5678", stored_password); end
    nCmp++; if (status_valid !== 1'b1 || return_status !== 3'd1) begin nErr++;
      $display("FAIL commit_status got valid %b status %0d want 1 1", status_valid, return_status); end
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL commit_busy got %b want 0", busy); end
    enter_btn = 1'b0; tick();
    nCmp++; if (commit_pulse !== 1'b0 || status_valid !== 1'b0) begin nErr++;
      $display("FAIL commit_one_cycle got commit %b valid %b want 0 0", commit_pulse, status_valid); end
    tick(); tick();
    nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL done_holds got busy %b want 0", busy); end
    gate_status = 3'd1; tick();
    gate_status = 3'd4; tick();
    nCmp++; if (busy !== 1'b1 || entry_digit !== 4'd1) begin nErr++;
      $display("FAIL reenter got busy %b digit %0d want 1 1", busy, entry_digit); end
  endtask

  task automatic test_mismatch();
    // buffer 1234 -> 5678, confirm with 5679
    pressUp(4); pressNext(1); pressUp(4); pressNext(1); pressUp(4); pressNext(1); pressUp(4);
    enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
    pressUp(5); pressNext(1); pressUp(6); pressNext(1); pressUp(7); pressNext(1); pressUp(9);
    enter_btn = 1'b1; tick();
    nCmp++; if (mismatch_pulse !== 1'b1) begin nErr++; $display("FAIL mismatch_pulse got %b want 1", mismatch_pulse); end
    nCmp++; if (commit_pulse !== 1'b0 || status_valid !== 1'b0) begin nErr++;
      $display("FAIL mismatch_no_commit got commit %b valid %b want 0 0", commit_pulse, status_valid); end
    nCmp++; if (busy !== 1'b1 || entry_index !== 2'd0 || entry_digit !== 4'd1) begin nErr++;
      $display("FAIL mismatch_reload got busy %b idx %0d digit %0d want 1 0 1", busy, entry_index, entry_digit); end
    nCmp++; if (stored_password !== 16'h5678) begin nErr++; $display("FAIL mismatch_stored got %h want 5678", stored_password); end
    enter_btn = 1'b0; tick();
    nCmp++; if (mismatch_pulse !== 1'b0) begin nErr++; $display("FAIL mismatch_one_cycle got %b want 0", mismatch_pulse); end
    pressNext(1);
    nCmp++; if (entry_digit !== 4'd2) begin nErr++; $display("FAIL mismatch_seed_nibble1 got %0d want 2", entry_digit); end
  endtask

  task automatic test_cancel_priority();
    enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
    enter_btn = 1'b1; cancel_btn = 1'b1; tick();
    nCmp++; if (status_valid !== 1'b1 || return_status !== 3'd1) begin nErr++;
      $display("FAIL cancel_status got valid %b status %0d want 1 1", status_valid, return_status); end
    nCmp++; if (commit_pulse !== 1'b0 || mismatch_pulse !== 1'b0) begin nErr++;
      $display("FAIL cancel_wins got commit %b mismatch %b want 0 0", commit_pulse, mismatch_pulse); end
    nCmp++; if (stored_password !== 16'h5678 || busy !== 1'b0) begin nErr++;
      $display("FAIL cancel_keep got stored %h busy %b want 5678 0", stored_password, busy); end
    enter_btn = 1'b0; cancel_btn = 1'b0; tick();
  endtask

  task automatic test_timeout();
    int early;
    gate_status = 3'd1; tick();
    gate_status = 3'd4; tick();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b1 || status_valid !== 1'b0) early++;
    end
    nCmp++; if (early !== 0) begin nErr++; $display("FAIL timeout_early got %0d early cycles want 0", early); end
    tick();
    nCmp++; if (status_valid !== 1'b1 || busy !== 1'b0 || return_status !== 3'd1) begin nErr++;
      $display("FAIL timeout_fire got valid %b busy %b status %0d want 1 0 1", status_valid, busy, return_status); end
    nCmp++; if (commit_pulse !== 1'b0 || stored_password !== 16'h5678) begin nErr++;
      $display("FAIL timeout_nocommit got commit %b stored %h want 0 5678", commit_pulse, stored_password); end
    // a button edge at cycle 10 restarts the idle count
    gate_status = 3'd1; tick();
    gate_status = 3'd4; tick();
    for (int i = 0; i < 9; i++) tick();
    up_btn = 1'b1; tick(); up_btn = 1'b0;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b1 || status_valid !== 1'b0) early++;
    end
    nCmp++; if (early !== 0) begin nErr++; $display("FAIL timeout_restart got %0d early cycles want 0", early); end
    tick();
    nCmp++; if (status_valid !== 1'b1 || busy !== 1'b0) begin nErr++;
      $display("FAIL timeout_restart_fire got valid %b busy %b want 1 0", status_valid, busy); end
  endtask

  task automatic test_gate_leave();
    gate_status = 3'd1; tick();
    seed_password = 16'h9ABC; start_index = 2'd2;
    gate_status = 3'd4; tick();
    nCmp++; if (entry_index !== 2'd2 || entry_digit !== 4'hB) begin nErr++;
      $display("FAIL start_index got idx %0d digit %h want 2 b", entry_index, entry_digit); end
    pressUp(1);
    nCmp++; if (entry_digit !== 4'd0) begin nErr++; $display("FAIL seed_above_max got %h want 0", entry_digit); end
    gate_status = 3'd1; tick();
    nCmp++; if (busy !== 1'b0 || status_valid !== 1'b0 || commit_pulse !== 1'b0) begin nErr++;
      $display("FAIL leave_silent got busy %b valid %b commit %b want 0 0 0", busy, status_valid, commit_pulse); end
    gate_status = 3'd4; tick();
    nCmp++; if (busy !== 1'b1 || entry_digit !== 4'hB) begin nErr++;
      $display("FAIL leave_reload got busy %b digit %h want 1 b", busy, entry_digit); end
  endtask

  task automatic test_reset_mid();
    enter_btn = 1'b1; tick(); enter_btn = 1'b0; tick();
    pressUp(1);
    nCmp++; if (busy !== 1'b1 || entry_digit !== 4'd1) begin nErr++;
      $display("FAIL mid_second got busy %b digit %0d want 1 1", busy, entry_digit); end
    #2 rst = 1'b1;
    #1;
    nCmp++; if (busy !== 1'b0 || stored_password !== 16'h0000 || return_status !== 3'd2) begin nErr++;
      $display("FAIL async_reset got busy %b stored %h status %0d want 0 0000 2", busy, stored_password, return_status); end
    nCmp++; if (entry_index !== 2'd0 || entry_digit !== 4'd0) begin nErr++;
      $display("FAIL async_reset_buf got idx %0d digit %0d want 0 0", entry_index, entry_digit); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_entry();
    test_up_next();
    test_commit();
    test_mismatch();
    test_cancel_priority();
    test_timeout();
    test_gate_leave();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
